// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, grant owner encoding
// and counter width helpers.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DM
   } owner_t;

   // Width able to hold the value n; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      int unsigned w;
      w = $clog2(n + 1);
      return (w == 0) ? 1 : w;
   endfunction

   localparam int unsigned MEM_LAT_DEF = 2;
   localparam int unsigned CNT_W       = cnt_w(MEM_LAT_DEF);

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// Combinational fetch/data winner select with a data-burst streak counter that
// forces a fetch grant after MAX_DATA_BURST consecutive data grants.
module arb_priority_pick
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_DATA_BURST = 3
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   if_req,
   input  logic   dm_req,
   input  logic   grant_en,
   output owner_t pick
);

   localparam int unsigned SW = cnt_w(MAX_DATA_BURST);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);

   logic [SW-1:0] streak_q;

   always_comb begin
      pick = OWN_NONE;
      if (dm_req && (!if_req || streak_q != STREAK_MAX))
         pick = OWN_DM;
      else if (if_req)
         pick = OWN_IF;
   end

   // Streak only counts data grants that actually made fetch wait.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak_q <= '0;
      end else if (grant_en) begin
         case (pick)
            OWN_DM: begin
               if (!if_req)
                  streak_q <= '0;
               else if (streak_q != STREAK_MAX)
                  streak_q <= streak_q + 1'b1;
            end
            OWN_IF:  streak_q <= '0;
            default: streak_q <= streak_q;
         endcase
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory shared by instruction fetch and data ports; one
// access in flight, fixed read latency, one-cycle ack and pipeline stall lines.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned MEM_LAT        = 2,
   parameter int unsigned MAX_DATA_BURST = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   localparam int unsigned LCW = cnt_w(MEM_LAT);
   localparam logic [LCW-1:0] LAT_C = LCW'(MEM_LAT);

   arb_state_t     state_q, state_d;
   owner_t         owner_q;
   owner_t         pick;
   logic [LCW-1:0] cnt_q;
   logic           lat_done;

   arb_priority_pick #(
      .MAX_DATA_BURST (MAX_DATA_BURST)
   ) u_pick (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .dm_req   (dm_req),
      .grant_en (state_q == IDLE),
      .pick     (pick)
   );

   assign lat_done = (cnt_q == LAT_C);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick != OWN_NONE) state_d = ACCESS;
         ACCESS:  state_d = WAIT;
         WAIT:    if (lat_done) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // mem_en/mem_we and the acks are registered one-cycle pulses, so they are
   // cleared every cycle and only re-armed on the transition that owns them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= OWN_NONE;
         cnt_q     <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
      end else begin
         state_q <= state_d;
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
         if_ack  <= 1'b0;
         dm_ack  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick != OWN_NONE) begin
                  owner_q <= pick;
                  mem_en  <= 1'b1;
                  if (pick == OWN_DM) begin
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     mem_we    <= dm_we;
                  end else begin
                     mem_addr  <= if_addr;
                  end
               end
            end
            ACCESS: cnt_q <= LCW'(1);
            WAIT: begin
               if (lat_done) begin
                  if (owner_q == OWN_IF) begin
                     if_rdata <= mem_rdata;
                     if_ack   <= 1'b1;
                  end else begin
                     dm_rdata <= mem_rdata;
                     dm_ack   <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               owner_q <= OWN_NONE;
               cnt_q   <= '0;
            end
            default: owner_q <= OWN_NONE;
         endcase
      end
   end

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a transaction-level timing
// model (grant cycle arithmetic plus burst-streak fairness rule).
module tb_unified_mem_arbiter;

   localparam int unsigned L    = 2;
   localparam int          MAXB = 3;
   localparam int          N    = 1500;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem, busy;

   always #5 clk = ~clk;

   unified_mem_arbiter #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .MEM_LAT        (L),
      .MAX_DATA_BURST (MAXB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ack    (dm_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .busy      (busy)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
   endfunction

   // Memory responder history: what the DUT strobed in each cycle.
   logic        en_hist  [0:N];
   logic [31:0] addr_hist[0:N];

   // Transaction model: one access granted at cycle g occupies g+1..g+L+2.
   bit          act;
   int          g, owner, streak;
   logic [31:0] m_addr, m_wdata;
   bit          m_we;
   bit          if_pend, dm_pend, prev_ifa, prev_dma;
   bit          e_busy, e_men, e_ifa, e_dma, idle_now;
   int          p;

   initial begin
      rst_n = 1'b0;  if_pend = 1'b1; dm_pend = 1'b0;
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
      act = 1'b0; g = 0; owner = 0; streak = 0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0; prev_ifa = 1'b0; prev_dma = 1'b0;

      for (cyc = 1; cyc <= N; cyc++) begin
         @(posedge clk); #1;
         rst_n = (cyc <= 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
         p = (cyc < 700) ? 35 : 100;
         if (prev_ifa) if_pend = 1'b0;
         if (prev_dma) dm_pend = 1'b0;
         if (!if_pend && $urandom_range(0, 99) < p) begin
            if_pend = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!dm_pend && $urandom_range(0, 99) < p) begin
            dm_pend  = 1'b1;
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_we    = ($urandom_range(0, 1) == 1);
            dm_wdata = $urandom;
         end
         if_req = if_pend;
         dm_req = dm_pend;
         mem_rdata = (cyc > int'(L) && en_hist[cyc-L] === 1'b1) ? mem_fn(addr_hist[cyc-L]) : $urandom;

         e_busy = act && cyc >= g + 1 && cyc <= g + int'(L) + 2;
         e_men  = act && cyc == g + 1;
         e_ifa  = act && owner == 1 && cyc == g + int'(L) + 2;
         e_dma  = act && owner == 2 && cyc == g + int'(L) + 2;

         @(negedge clk);
         en_hist[cyc]   = mem_en;
         addr_hist[cyc] = mem_addr;

         check_eq("busy",      busy,      e_busy);
         check_eq("mem_en",    mem_en,    e_men);
         check_eq("if_ack",    if_ack,    e_ifa);
         check_eq("dm_ack",    dm_ack,    e_dma);
         check_eq("stall_if",  stall_if,  if_req & ~e_ifa);
         check_eq("stall_mem", stall_mem, dm_req & ~e_dma);
         if (e_men) begin
            check_eq("mem_addr", mem_addr, m_addr);
            check_eq("mem_we",   mem_we,   m_we);
            if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
         end
         if (e_ifa) check_eq("if_rdata", if_rdata, mem_fn(m_addr));
         if (e_dma) check_eq("dm_rdata", dm_rdata, mem_fn(m_addr));
         if (cyc <= 2) begin
            check_eq("rst_maddr", mem_addr,  32'h0);
            check_eq("rst_wdata", mem_wdata, 32'h0);
            check_eq("rst_ifrd",  if_rdata,  32'h0);
            check_eq("rst_dmrd",  dm_rdata,  32'h0);
            check_eq("rst_we",    mem_we,    32'h0);
         end

         prev_ifa = e_ifa;
         prev_dma = e_dma;

         if (!rst_n) begin
            act = 1'b0;
            streak = 0;
         end else begin
            idle_now = !act;
            if (act && cyc == g + int'(L) + 2) act = 1'b0;
            if (idle_now && (if_req || dm_req)) begin
               act = 1'b1;
               g   = cyc;
               if (dm_req && (!if_req || streak < MAXB)) begin
                  owner   = 2;
                  m_addr  = dm_addr;
                  m_we    = dm_we;
                  m_wdata = dm_wdata;
                  streak  = if_req ? ((streak + 1 > MAXB) ? MAXB : streak + 1) : 0;
               end else begin
                  owner  = 1;
                  m_addr = if_addr;
                  m_we   = 1'b0;
                  streak = 0;
               end
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
